// File: rtl/decodificador_teclado.sv
// 4x4 active-low keypad scanner with press/release debounce, a 20-nibble key
// buffer for the lock controller and an inactivity timeout code.
module decodificador_teclado #(
    parameter int DEBOUNCE_CYC = 50,
    parameter int TIMEOUT_CYC  = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        teclado_en,
    input  logic [3:0]  lin_matrix,
    output logic [3:0]  col_matrix,
    output logic [79:0] digitos_value,
    output logic        digitos_valid
);

    // state        | meaning
    // SCAN         | rotate the one-cold column drive, look for a single low row
    // DEBOUNCE     | column frozen, count stable cycles of the latched row
    // WAIT_RELEASE | key accepted, wait for a stable all-high release
    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        WAIT_RELEASE
    } state_t;

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [79:0]   ALL_F    = {20{4'hF}};
    localparam logic [79:0]   ALL_E    = {20{4'hE}};

    state_t        state;
    logic [3:0]    row_lat;
    logic [DW-1:0] deb_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_armed;
    logic          clear_next;

    logic          one_low;
    logic [1:0]    row_idx;
    logic [1:0]    col_idx;
    logic [3:0]    key_code;
    logic          key_valid;
    logic          key_end;
    logic          accept;
    logic          tmo_hit;
    logic [79:0]   buf_now;

    function automatic logic [1:0] zero_idx(input logic [3:0] v);
        case (v)
            4'b1110: zero_idx = 2'd0;
            4'b1101: zero_idx = 2'd1;
            4'b1011: zero_idx = 2'd2;
            default: zero_idx = 2'd3;
        endcase
    endfunction

    assign one_low = (lin_matrix == 4'b1110) || (lin_matrix == 4'b1101) ||
                     (lin_matrix == 4'b1011) || (lin_matrix == 4'b0111);
    assign row_idx = zero_idx(row_lat);
    assign col_idx = zero_idx(col_matrix);

    always_comb begin
        key_code = 4'hF;
        case ({row_idx, col_idx})
            4'b00_00: key_code = 4'h1;
            4'b00_01: key_code = 4'h2;
            4'b00_10: key_code = 4'h3;
            4'b01_00: key_code = 4'h4;
            4'b01_01: key_code = 4'h5;
            4'b01_10: key_code = 4'h6;
            4'b10_00: key_code = 4'h7;
            4'b10_01: key_code = 4'h8;
            4'b10_10: key_code = 4'h9;
            4'b11_00: key_code = 4'hA;
            4'b11_01: key_code = 4'h0;
            4'b11_10: key_code = 4'hB;
            default:  key_code = 4'hF;
        endcase
    end

    assign key_valid = (col_idx != 2'd3);
    assign key_end   = (key_code == 4'hA) || (key_code == 4'hB);
    assign accept    = (state == DEBOUNCE) && (lin_matrix == row_lat) && (deb_cnt == DEB_LAST);
    assign tmo_hit   = tmo_armed && (tmo_cnt == TMO_LAST);
    // A pending clear must not leak stale digits into a shift in the same cycle.
    assign buf_now   = clear_next ? ALL_F : digitos_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SCAN;
            col_matrix    <= 4'b1110;
            row_lat       <= 4'b1111;
            deb_cnt       <= '0;
            tmo_cnt       <= '0;
            tmo_armed     <= 1'b0;
            clear_next    <= 1'b0;
            digitos_value <= ALL_F;
            digitos_valid <= 1'b0;
        end else if (!teclado_en) begin
            state         <= SCAN;
            col_matrix    <= 4'b1111;
            row_lat       <= 4'b1111;
            deb_cnt       <= '0;
            tmo_cnt       <= '0;
            tmo_armed     <= 1'b0;
            clear_next    <= 1'b0;
            digitos_value <= ALL_F;
            digitos_valid <= 1'b0;
        end else begin
            digitos_valid <= 1'b0;
            if (clear_next) begin
                digitos_value <= ALL_F;
                clear_next    <= 1'b0;
            end
            if (tmo_armed) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            case (state)
                SCAN: begin
                    if (one_low) begin
                        row_lat <= lin_matrix;
                        deb_cnt <= '0;
                        state   <= DEBOUNCE;
                    end else if (col_matrix == 4'b1111) begin
                        col_matrix <= 4'b1110;
                    end else begin
                        col_matrix <= {col_matrix[2:0], col_matrix[3]};
                    end
                end
                DEBOUNCE: begin
                    if (lin_matrix != row_lat) begin
                        state <= SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt <= '0;
                        state   <= WAIT_RELEASE;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    if (lin_matrix != 4'b1111) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt <= '0;
                        state   <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase

            // An accepted key takes priority over a coincident timeout expiry.
            if (accept && key_valid) begin
                digitos_value <= {buf_now[75:0], key_code};
                digitos_valid <= 1'b1;
                tmo_cnt       <= '0;
                tmo_armed     <= !key_end;
                clear_next    <= key_end;
            end else if (tmo_hit) begin
                digitos_value <= ALL_E;
                digitos_valid <= 1'b1;
                tmo_cnt       <= '0;
                tmo_armed     <= 1'b0;
                clear_next    <= 1'b1;
            end
        end
    end

endmodule

// File: doc/decodificador_teclado.md
Name: decodificador_teclado

Overview:
- Upstream neighbour of the operational lock controller.
- Scans a 4x4 active-low keypad matrix and debounces each key press.
- Accumulates key codes into a 20-nibble shift buffer and delivers it as digitos_value / digitos_valid, the format the operational block consumes.
- Generates the inactivity-timeout code (all 0xE) and enters idle under control of the teclado_en line driven by the operational block.

Parameters:
- DEBOUNCE_CYC, 50: consecutive stable cycles needed to accept a press and to confirm a release.
- TIMEOUT_CYC, 5000: idle cycles after the last accepted key before the timeout code is emitted (5 s at 1 kHz).

Ports:
- clk  in  1  system clock, 1 kHz.
- rst  in  1  synchronous, active-high reset.
- teclado_en  in  1  keypad enable from the operational block.
- lin_matrix  in  4  row lines; low = key closed in the driven column.
- col_matrix  out  4  column drive, one-cold.
- digitos_value  out  80  senhaPac_t; field digits[19:0] holds 4-bit codes, digits[0] is newest.
- digitos_valid  out  1  one-cycle strobe qualifying digitos_value.

Behaviour:
- Reset values:
  - col_matrix = 4'b1110.
  - digitos_value = all 1s (every nibble 0xF).
  - digitos_valid = 0.
  - FSM = SCAN; debounce and timeout counters = 0.
- Key map, row r / column c:
  - r0: 1 2 3 -
  - r1: 4 5 6 -
  - r2: 7 8 9 -
  - r3: * 0 # -
  - '*' gives code 0xA and '#' gives 0xB. Column 3 ("-") is ignored: it is debounced but produces no output.
- SCAN:
  - If lin_matrix == 4'b1111, col_matrix rotates one-cold (1110 -> 1101 -> 1011 -> 0111 -> 1110), one column per cycle.
  - If exactly one line is low, freeze the column, latch the row, clear the debounce counter and go to DEBOUNCE.
  - If more than one line is low, ignore it and keep rotating.
- DEBOUNCE:
  - Same single line low: increment the counter. When it reaches DEBOUNCE_CYC, accept the key and go to WAIT_RELEASE.
  - Any other line pattern: back to SCAN with no output.
- Accept (the cycle after the counter reaches DEBOUNCE_CYC):
  - digits <= {digits[18:0], code}; the oldest nibble is discarded, so a full buffer simply shifts.
  - digitos_valid = 1 for exactly one cycle, with the new digitos_value in that same cycle.
  - Timeout counter cleared and armed.
- After accepting 0xA or 0xB:
  - The next cycle, digitos_value returns to all 0xF.
  - The timeout is disarmed.
- WAIT_RELEASE:
  - Requires lin_matrix == 4'b1111 for DEBOUNCE_CYC consecutive cycles, then returns to SCAN.
  - Any low line restarts that count.
  - A held key never repeats.
- Timeout:
  - Armed while the buffer holds at least one non-0xF nibble.
  - Counts every cycle; on reaching TIMEOUT_CYC, drive digitos_value = {20{4'hE}} with digitos_valid = 1 for one cycle.
  - The next cycle, the buffer returns to all 0xF and the timeout is disarmed.
- Simultaneous key accept and timeout expiry in the same cycle: the key wins, the timeout does not fire, and the counter restarts.
- Outside strobes, digitos_value holds its last value; it changes only on accept, timeout, clear, enable-low or reset.
- teclado_en low:
  - Takes effect the next cycle: col_matrix = 4'b1111, FSM forced to SCAN, buffer all 0xF, counters cleared, digitos_valid = 0.
  - All inputs are ignored while low.
  - On the rising edge of teclado_en, scanning restarts at col_matrix = 4'b1110.
- rst mid-press or mid-debounce: all state returns to reset values in the next cycle and no strobe is emitted.

Test Plan:
- Press '1' (r0/c0 low) for 60 cycles, then release -> exactly one digitos_valid pulse 51 cycles after the press is first seen; digits[0] = 0x1, digits[19:1] = 0xF; no repeat while held.
- Key bounces low/high every 10 cycles for 40 cycles, then holds low 60 cycles -> a single strobe only after the stable run; no strobe during bouncing.
- Enter 1,2,3,4 then '#' -> five strobes, the last with digits[4:0] = {1,2,3,4,B}; one cycle later digitos_value = all 1s.
- Enter '5', then stay idle 5000 cycles -> strobe with digitos_value = {20{4'hE}}, buffer then all 0xF; a further 6000 idle cycles -> no strobe.
- Enter 22 digits '7' -> digits[19:0] all 0x7, no overflow error; drop teclado_en -> col_matrix = 4'b1111, buffer all 0xF, no strobes while low.
- Assert rst during DEBOUNCE of key '0' -> no strobe; col_matrix = 4'b1110 and digitos_value = all 1s one cycle after rst.
